// File: rtl/airi5c_hasti_periph_bridge_pkg.sv
// Shared HASTI bus definitions used by the peripheral bridge and other HASTI slaves.
package airi5c_hasti_periph_bridge_pkg;

  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_BUS_WIDTH   = 32;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_TRANS_WIDTH = 2;
  localparam int HASTI_RESP_WIDTH  = 1;

  typedef enum logic [HASTI_TRANS_WIDTH-1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [HASTI_SIZE_WIDTH-1:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic [HASTI_RESP_WIDTH-1:0] {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

endpackage

// File: rtl/airi5c_hasti_strb_gen.sv
// Byte-enable and misalignment decode for a HASTI transfer (size + low address bits).
module airi5c_hasti_strb_gen
  import airi5c_hasti_periph_bridge_pkg::*;
(
  input  logic [HASTI_SIZE_WIDTH-1:0] hsize,
  input  logic [1:0]                  addr,
  output logic [3:0]                  be,
  output logic                        misaligned
);

  // Lane selection per transfer size; anything wider than a word is rejected as misaligned.
  always_comb begin
    be         = 4'b0000;
    misaligned = 1'b0;
    case (hsize)
      HSIZE_BYTE: be = 4'b0001 << addr;
      HSIZE_HALF: begin
        be         = addr[1] ? 4'b1100 : 4'b0011;
        misaligned = addr[0];
      end
      HSIZE_WORD: begin
        be         = 4'b1111;
        misaligned = (addr != 2'b00);
      end
      default:    misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/airi5c_hasti_periph_bridge.sv
// HASTI responder that converts bus transfers into a req/ack register interface
// for a single peripheral, with wait states, error responses and an ack timeout.
module airi5c_hasti_periph_bridge
  import airi5c_hasti_periph_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         hsel_i,
  input  logic [HASTI_ADDR_WIDTH-1:0]  haddr_i,
  input  logic                         hwrite_i,
  input  logic [HASTI_SIZE_WIDTH-1:0]  hsize_i,
  input  logic [HASTI_TRANS_WIDTH-1:0] htrans_i,
  input  logic [HASTI_BUS_WIDTH-1:0]   hwdata_i,
  input  logic                         hready_i,
  output logic                         hready_o,
  output logic [HASTI_RESP_WIDTH-1:0]  hresp_o,
  output logic [HASTI_BUS_WIDTH-1:0]   hrdata_o,
  output logic                         p_req_o,
  output logic                         p_we_o,
  output logic [ADDR_WIDTH-1:0]        p_addr_o,
  output logic [3:0]                   p_be_o,
  output logic [31:0]                  p_wdata_o,
  input  logic [31:0]                  p_rdata_i,
  input  logic                         p_ack_i,
  input  logic                         p_err_i
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_ERR1   = 2'b10,
    ST_ERR2   = 2'b11
  } state_e;

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  state_e                state_q, state_d, accept_target;
  logic                  accept, take, ack_ok;
  logic [3:0]            be;
  logic                  misaligned;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [3:0]            be_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  unused_bits;

  assign unused_bits = ^{haddr_i[HASTI_ADDR_WIDTH-1:ADDR_WIDTH], htrans_i[0]};

  airi5c_hasti_strb_gen u_strb_gen (
    .hsize      (hsize_i),
    .addr       (haddr_i[1:0]),
    .be         (be),
    .misaligned (misaligned)
  );

  // A new transfer is taken only where the bridge is ready to start one:
  // idle, the second error cycle, or the successful ack cycle of an access.
  assign accept        = hsel_i & hready_i & htrans_i[1];
  assign ack_ok        = p_ack_i & ~p_err_i;
  assign take          = accept & ((state_q == ST_IDLE) | (state_q == ST_ERR2) |
                                   ((state_q == ST_ACCESS) & ack_ok));
  assign accept_target = misaligned ? ST_ERR1 : ST_ACCESS;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ERR2: state_d = take ? accept_target : ST_IDLE;
      ST_ACCESS: begin
        if (p_ack_i) begin
          if (p_err_i)   state_d = ST_ERR2;
          else if (take) state_d = accept_target;
          else           state_d = ST_IDLE;
        end else if ((TIMEOUT > 0) && (cnt_q == CNT_LIMIT)) begin
          state_d = ST_ERR1;
        end
      end
      ST_ERR1:  state_d = ST_ERR2;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Bus response and peripheral request decoded from the current state.
  always_comb begin
    hready_o = 1'b1;
    hresp_o  = HRESP_OKAY;
    hrdata_o = '0;
    p_req_o  = 1'b0;
    case (state_q)
      ST_ACCESS: begin
        p_req_o = 1'b1;
        if (p_ack_i && p_err_i) begin
          hready_o = 1'b0;
          hresp_o  = HRESP_ERROR;
        end else if (p_ack_i) begin
          hrdata_o = we_q ? '0 : p_rdata_i;
        end else begin
          hready_o = 1'b0;
        end
      end
      ST_ERR1: begin
        hready_o = 1'b0;
        hresp_o  = HRESP_ERROR;
      end
      ST_ERR2:  hresp_o = HRESP_ERROR;
      default: ;
    endcase
  end

  // Address-phase capture of offset, direction and byte lanes for the data phase.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q <= '0;
      we_q   <= 1'b0;
      be_q   <= 4'b0000;
    end else if (take) begin
      addr_q <= haddr_i[ADDR_WIDTH-1:0];
      we_q   <= hwrite_i;
      be_q   <= be;
    end
  end

  // Wait-cycle counter: runs while an access is waiting for ack, zero otherwise,
  // so every fresh access starts counting from zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                                 cnt_q <= '0;
    else if ((state_q == ST_ACCESS) && !p_ack_i) cnt_q <= cnt_q + 1'b1;
    else                                         cnt_q <= '0;
  end

  assign p_we_o    = we_q;
  assign p_addr_o  = addr_q;
  assign p_be_o    = be_q;
  assign p_wdata_o = hwdata_i;

endmodule

// File: tb/tb_airi5c_hasti_periph_bridge.sv
// Self-checking bench: directed scenarios followed by random transfers, each
// checked cycle by cycle against a transaction-level response model.
module tb_airi5c_hasti_periph_bridge;
  import airi5c_hasti_periph_bridge_pkg::*;

  localparam int TIMEOUT_P = 4;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic        err;
  } xfer_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        hsel_i, hwrite_i;
  logic [31:0] haddr_i, hwdata_i, hrdata_o;
  logic [2:0]  hsize_i;
  logic [1:0]  htrans_i;
  logic        hready_o;
  logic [0:0]  hresp_o;
  logic        p_req_o, p_we_o;
  logic [7:0]  p_addr_o;
  logic [3:0]  p_be_o;
  logic [31:0] p_wdata_o, p_rdata_i;
  logic        p_ack_i, p_err_i;
  wire         hready_bus;

  int checks = 0;
  int errors = 0;
  xfer_t noXfer;

  // The bus-wide hready comes back from the read mux; this slave is the only one.
  assign hready_bus = hready_o;

  always #5 clk_i = ~clk_i;

  airi5c_hasti_periph_bridge #(.ADDR_WIDTH(8), .TIMEOUT(TIMEOUT_P)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .hsel_i(hsel_i), .haddr_i(haddr_i),
    .hwrite_i(hwrite_i), .hsize_i(hsize_i), .htrans_i(htrans_i), .hwdata_i(hwdata_i),
    .hready_i(hready_bus), .hready_o(hready_o), .hresp_o(hresp_o), .hrdata_o(hrdata_o),
    .p_req_o(p_req_o), .p_we_o(p_we_o), .p_addr_o(p_addr_o), .p_be_o(p_be_o),
    .p_wdata_o(p_wdata_o), .p_rdata_i(p_rdata_i), .p_ack_i(p_ack_i), .p_err_i(p_err_i)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic xfer_t mk(input logic [31:0] addr, input logic write, input logic [2:0] size,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input int delay, input logic err);
    xfer_t t;
    t.addr = addr; t.write = write; t.size = size; t.wdata = wdata;
    t.rdata = rdata; t.delay = delay; t.err = err;
    return t;
  endfunction

  // Model: a transfer is misaligned when wider than a word or not a multiple of its size.
  function automatic bit isMisaligned(input xfer_t t);
    int nbytes;
    if (t.size > 3'd2) return 1'b1;
    nbytes = 1 << t.size;
    return (t.addr % nbytes) != 0;
  endfunction

  // Model: a run of nbytes lanes starting at the byte offset within the word.
  function automatic logic [3:0] expBe(input xfer_t t);
    int nbytes;
    int lanes;
    nbytes = 1 << t.size;
    lanes  = (1 << nbytes) - 1;
    return 4'(lanes << (t.addr % 4));
  endfunction

  function automatic xfer_t randXfer();
    xfer_t t;
    t.addr  = $urandom;
    t.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    if (t.size <= 3'd2 && $urandom_range(0, 9) < 7)
      t.addr = t.addr & ~((32'd1 << t.size) - 32'd1);
    t.write = 1'($urandom);
    t.wdata = $urandom;
    t.rdata = $urandom;
    t.delay = $urandom_range(0, 6);
    t.err   = ($urandom_range(0, 4) == 0);
    return t;
  endfunction

  task automatic startCycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input bit present, input xfer_t a, input logic [31:0] wdata,
                               input logic ack, input logic err, input logic [31:0] rdata);
    if (present) begin
      hsel_i   = 1'b1;
      htrans_i = $urandom_range(0, 1) ? HTRANS_NONSEQ : HTRANS_SEQ;
      haddr_i  = a.addr;
      hwrite_i = a.write;
      hsize_i  = a.size;
    end else begin
      hsel_i   = 1'($urandom);
      htrans_i = $urandom_range(0, 1) ? HTRANS_IDLE : HTRANS_BUSY;
      haddr_i  = $urandom;
      hwrite_i = 1'($urandom);
      hsize_i  = 3'($urandom_range(0, 2));
    end
    hwdata_i  = wdata;
    p_ack_i   = ack;
    p_err_i   = err;
    p_rdata_i = rdata;
  endtask

  task automatic checkCycle(input string tag, input logic hr, input logic resp, input logic req,
                            input logic [31:0] rd, input bit chkP, input xfer_t t);
    checkOutput({tag, " hready"}, 32'(hready_o), 32'(hr));
    checkOutput({tag, " hresp"}, 32'(hresp_o), 32'(resp));
    checkOutput({tag, " p_req"}, 32'(p_req_o), 32'(req));
    checkOutput({tag, " hrdata"}, hrdata_o, rd);
    if (chkP) begin
      checkOutput({tag, " p_we"}, 32'(p_we_o), 32'(t.write));
      checkOutput({tag, " p_addr"}, 32'(p_addr_o), 32'(t.addr[7:0]));
      checkOutput({tag, " p_be"}, 32'(p_be_o), 32'(expBe(t)));
      checkOutput({tag, " p_wdata"}, p_wdata_o, t.wdata);
    end
  endtask

  task automatic idleCycle(input string tag);
    startCycle();
    applyStimulus(1'b0, noXfer, $urandom, 1'($urandom), 1'($urandom), $urandom);
    #1;
    checkCycle(tag, 1'b1, HRESP_OKAY, 1'b0, 32'h0, 1'b0, noXfer);
  endtask

  task automatic addrCycle(input string tag, input xfer_t t);
    startCycle();
    applyStimulus(1'b1, t, $urandom, 1'($urandom), 1'($urandom), $urandom);
    #1;
    checkCycle({tag, " addr"}, 1'b1, HRESP_OKAY, 1'b0, 32'h0, 1'b0, noXfer);
  endtask

  // Two-cycle error response; the next address may be offered in the second cycle.
  task automatic errTail(input string tag, input bit withErr1, input bit hasNext, input xfer_t nx);
    if (withErr1) begin
      startCycle();
      applyStimulus(1'b0, nx, $urandom, 1'($urandom), 1'($urandom), $urandom);
      #1;
      checkCycle({tag, " err1"}, 1'b0, HRESP_ERROR, 1'b0, 32'h0, 1'b0, noXfer);
    end
    startCycle();
    applyStimulus(hasNext, nx, $urandom, 1'($urandom), 1'($urandom), $urandom);
    #1;
    checkCycle({tag, " err2"}, 1'b1, HRESP_ERROR, 1'b0, 32'h0, 1'b0, noXfer);
  endtask

  task automatic waitCycle(input string tag, input xfer_t t);
    startCycle();
    applyStimulus(1'b0, noXfer, t.wdata, 1'b0, 1'($urandom), $urandom);
    #1;
    checkCycle({tag, " wait"}, 1'b0, HRESP_OKAY, 1'b1, 32'h0, 1'b1, t);
  endtask

  // Full data phase of t; nx is offered in the final ready cycle when hasNext is set.
  task automatic dataPhase(input string tag, input xfer_t t, input bit hasNext, input xfer_t nx);
    if (isMisaligned(t)) begin
      errTail({tag, " misal"}, 1'b1, hasNext, nx);
    end else if (t.delay > TIMEOUT_P) begin
      for (int k = 0; k <= TIMEOUT_P; k++) waitCycle(tag, t);
      errTail({tag, " tmo"}, 1'b1, hasNext, nx);
    end else begin
      for (int k = 0; k < t.delay; k++) waitCycle(tag, t);
      startCycle();
      if (t.err) begin
        applyStimulus(1'b0, noXfer, t.wdata, 1'b1, 1'b1, t.rdata);
        #1;
        checkCycle({tag, " ackerr"}, 1'b0, HRESP_ERROR, 1'b1, 32'h0, 1'b1, t);
        errTail({tag, " ackerr"}, 1'b0, hasNext, nx);
      end else begin
        applyStimulus(hasNext, nx, t.wdata, 1'b1, 1'b0, t.rdata);
        #1;
        checkCycle({tag, " ack"}, 1'b1, HRESP_OKAY, 1'b1, t.write ? 32'h0 : t.rdata, 1'b1, t);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    xfer_t t0, t1, cur, nxt;
    bit b2b;
    noXfer = mk(32'h0, 1'b0, 3'd2, 32'h0, 32'h0, 0, 1'b0);
    rst_ni = 1'b0;
    applyStimulus(1'b0, noXfer, 32'h0, 1'b0, 1'b0, 32'h0);

    // Reset values.
    repeat (2) begin
      startCycle();
      applyStimulus(1'b0, noXfer, $urandom, 1'($urandom), 1'($urandom), $urandom);
      #1;
      checkCycle("reset", 1'b1, HRESP_OKAY, 1'b0, 32'h0, 1'b0, noXfer);
      checkOutput("reset p_we", 32'(p_we_o), 32'h0);
      checkOutput("reset p_addr", 32'(p_addr_o), 32'h0);
      checkOutput("reset p_be", 32'(p_be_o), 32'h0);
    end
    rst_ni = 1'b1;
    idleCycle("idle");

    $display("[TB] directed transfers");
    t0 = mk(32'hC000_0304, 1'b1, 3'd2, 32'hA5A5_A5A5, 32'h1234_5678, 0, 1'b0);
    addrCycle("wordwr", t0);
    dataPhase("wordwr", t0, 1'b0, noXfer);
    idleCycle("wordwr after");

    t0 = mk(32'hC000_0306, 1'b0, 3'd0, 32'h0, 32'h00AB_0000, 3, 1'b0);
    addrCycle("byterd", t0);
    dataPhase("byterd", t0, 1'b0, noXfer);

    t0 = mk(32'hC000_0301, 1'b0, 3'd1, 32'h0, 32'h0, 0, 1'b0);
    addrCycle("half01", t0);
    dataPhase("half01", t0, 1'b0, noXfer);
    idleCycle("half01 after");

    t0 = mk(32'hC000_0300, 1'b0, 3'd2, 32'h0, 32'h1111_2222, 0, 1'b0);
    t1 = mk(32'hC000_0304, 1'b0, 3'd2, 32'h0, 32'h3333_4444, 0, 1'b0);
    addrCycle("b2b0", t0);
    dataPhase("b2b0", t0, 1'b1, t1);
    dataPhase("b2b1", t1, 1'b0, noXfer);

    t0 = mk(32'hC000_0308, 1'b1, 3'd2, 32'hDEAD_BEEF, 32'h0, 99, 1'b0);
    addrCycle("timeout", t0);
    dataPhase("timeout", t0, 1'b0, noXfer);
    idleCycle("timeout after");

    t0 = mk(32'hC000_030C, 1'b1, 3'd2, 32'hCAFE_F00D, 32'h0, 1, 1'b1);
    addrCycle("wrerr", t0);
    dataPhase("wrerr", t0, 1'b0, noXfer);

    // Reset asserted in the middle of a waiting access.
    t0 = mk(32'hC000_0310, 1'b1, 3'd2, 32'h5555_AAAA, 32'h0, 99, 1'b0);
    addrCycle("midrst", t0);
    waitCycle("midrst", t0);
    startCycle();
    rst_ni = 1'b0;
    applyStimulus(1'b0, noXfer, t0.wdata, 1'b0, 1'b0, $urandom);
    #1;
    checkCycle("midrst held", 1'b0, HRESP_OKAY, 1'b1, 32'h0, 1'b1, t0);
    startCycle();
    rst_ni = 1'b1;
    applyStimulus(1'b0, noXfer, $urandom, 1'b0, 1'b0, $urandom);
    #1;
    checkCycle("midrst after", 1'b1, HRESP_OKAY, 1'b0, 32'h0, 1'b0, noXfer);
    checkOutput("midrst p_addr", 32'(p_addr_o), 32'h0);
    checkOutput("midrst p_be", 32'(p_be_o), 32'h0);
    idleCycle("midrst idle");

    $display("[TB] random transfers");
    cur = randXfer();
    addrCycle("rand", cur);
    for (int i = 0; i < 200; i++) begin
      nxt = randXfer();
      b2b = 1'($urandom);
      dataPhase("rand", cur, b2b, nxt);
      if (!b2b) begin
        repeat ($urandom_range(0, 2)) idleCycle("rand idle");
        addrCycle("rand", nxt);
      end
      cur = nxt;
    end
    dataPhase("rand last", cur, 1'b0, noXfer);
    idleCycle("final idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/airi5c_hasti_periph_bridge.md
Name: airi5c_hasti_periph_bridge

Overview:
- HASTI (AHB-Lite) responder that turns bus transfers into a simple request/acknowledge register interface for one internal peripheral.
- Sits behind the peripheral read mux: its hready_o, hresp_o and hrdata_o feed one slot of that mux's s_hready, s_hresp and s_hrdata vectors.
- Handles wait states, byte enables, misalignment errors and an acknowledge timeout.
- Peripherals then implement only register logic.

Parameters:
- ADDR_WIDTH, 8, width of the peripheral offset; p_addr_o = haddr_i[ADDR_WIDTH-1:0] latched in the address phase.
- TIMEOUT, 255, maximum wait cycles for p_ack_i before an error response; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- hsel_i  in  1  slave select from the address decoder
- haddr_i  in  `HASTI_ADDR_WIDTH  address
- hwrite_i  in  1  write
- hsize_i  in  `HASTI_SIZE_WIDTH  transfer size
- htrans_i  in  `HASTI_TRANS_WIDTH  transfer type
- hwdata_i  in  `HASTI_BUS_WIDTH  write data, valid in the data phase
- hready_i  in  1  bus-wide hready, taken from the mux output
- hready_o  out  1  slave hready
- hresp_o  out  `HASTI_RESP_WIDTH  response
- hrdata_o  out  `HASTI_BUS_WIDTH  read data
- p_req_o  out  1  peripheral access request
- p_we_o  out  1  write enable
- p_addr_o  out  ADDR_WIDTH  register offset
- p_be_o  out  4  byte enables
- p_wdata_o  out  32  write data, equal to hwdata_i
- p_rdata_i  in  32  read data, valid together with p_ack_i
- p_ack_i  in  1  access complete
- p_err_i  in  1  access failed, qualified by p_ack_i

Behaviour:
- Reset values (rst_ni=0 at a clock edge):
  - state=IDLE, hready_o=1, hresp_o=OKAY, hrdata_o=0.
  - p_req_o=0, p_we_o=0, p_addr_o=0, p_be_o=0, timeout counter 0.
  - Reset mid-transfer abandons the access silently.
- Accept condition: hsel_i & hready_i & htrans_i[1] (NONSEQ or SEQ).
  - On accept, latch the offset, hwrite_i, the byte enables and the misalign flag.
  - IDLE/BUSY transfers get a zero-wait OKAY and cause no peripheral access.
- Byte enables (from hsize_i, haddr_i[1:0]):
  - Byte: one-hot at the addressed lane.
  - Half: 4'b0011 or 4'b1100.
  - Word: 4'b1111.
  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or hsize>2.
- IDLE:
  - hready_o=1, hresp_o=OKAY.
  - On accept: go to ERR1 if misaligned, else ACCESS.
- ACCESS:
  - p_req_o=1 (combinational from state); p_wdata_o=hwdata_i; timeout counter increments each cycle.
  - p_ack_i & ~p_err_i: hready_o=1, hresp_o=OKAY, hrdata_o=p_rdata_i for reads (0 for writes). Next state is ACCESS/ERR1 if a new transfer is accepted in the same cycle (back-to-back, no bubble), else IDLE.
  - p_ack_i & p_err_i: hready_o=0, hresp_o=ERROR (this cycle is the first error cycle); go to ERR2.
  - No ack: hready_o=0, hresp_o=OKAY. When the counter reaches TIMEOUT (TIMEOUT>0), drop p_req_o next cycle and go to ERR1.
  - Latency: read data returns in the p_ack_i cycle; minimum is zero wait states if the peripheral acks in the first ACCESS cycle.
- ERR1:
  - hready_o=0, hresp_o=ERROR, p_req_o=0; go to ERR2.
  - Address-phase inputs are ignored.
- ERR2:
  - hready_o=1, hresp_o=ERROR.
  - A transfer accepted here is handled as from IDLE.
  - If the master issues IDLE after an error, return to IDLE.
- Misc:
  - Timeout counter clears on every entry to ACCESS.
  - p_ack_i outside ACCESS is ignored.
  - hrdata_o=0 whenever not in an acknowledged read cycle.

Decomposition:
- Shared package/include (alongside the existing HASTI defines):
  - HTRANS codes IDLE/BUSY/NONSEQ/SEQ.
  - HSIZE codes BYTE/HALF/WORD.
  - RESP codes OKAY/ERROR.
- Local: 2-bit state encoding IDLE/ACCESS/ERR1/ERR2.
- One sub-module: airi5c_hasti_strb_gen (combinational hsize/addr -> p_be, misaligned flag), reusable by other HASTI slaves.

Test Plan:
- Word write, haddr=0xC0000304, wdata=0xA5A5A5A5, p_ack_i held high -> p_req_o=1 for 1 cycle, p_addr_o=0x04, p_be_o=4'b1111, p_we_o=1, hready_o=1, hresp_o=OKAY.
- Byte read at offset 0x06, peripheral acks after 3 cycles with p_rdata_i=0x00AB0000 -> hready_o low for 3 cycles, p_be_o=4'b0100, hrdata_o=0x00AB0000 in the ack cycle.
- Half access at offset 0x01 -> no p_req_o; hready_o/hresp_o = 0/ERROR then 1/ERROR.
- Two back-to-back NONSEQ reads, zero-wait peripheral -> two consecutive p_req_o cycles with offsets 0x00 and 0x04, no idle cycle between.
- TIMEOUT=4, peripheral never acks -> p_req_o high for 5 cycles, then the ERR1/ERR2 two-cycle error.
- p_ack_i & p_err_i on a write -> hready_o=0/ERROR that cycle, 1/ERROR next. Assert rst_ni=0 during ACCESS -> next cycle hready_o=1, p_req_o=0, state IDLE.
